// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSD first,
// start/busy/done handshake, carry and signed-overflow flags on completion.

module digit_serial_addsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;

    logic [DIGIT:0]       c;
    logic [DIGIT-1:0]     sum_dig;
    logic [WIDTH+DIGIT-1:0] acc_cat;

    // Operands shift right each cycle so the active digit is always the low slice.
    assign c[0] = carry;
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
        digit_serial_addsub_fa u_fa (
            .a  (op_a[i]),
            .b  (op_b[i]),
            .ci (c[i]),
            .s  (sum_dig[i]),
            .co (c[i+1])
        );
    end

    // New digit enters at the top; after NDIG cycles the word is in order.
    assign acc_cat  = {sum_dig, acc};
    assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
    assign last     = (cnt == CW'(NDIG - 1));
    assign busy     = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{mode}};
                        carry <= mode;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    carry <= c[DIGIT];
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        s    <= acc_next;
                        cout <= c[DIGIT];
                        ovf  <= c[DIGIT-1] ^ c[DIGIT];
                        done <= 1'b1;
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed table plus handshake/reset sequences on DIGIT=4, random sweep on DIGIT=1/4/16.

module tb_digit_serial_addsub;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0, b = '0;

    logic busy4, done4, cout4, ovf4;  logic [W-1:0] s4;
    logic busy1, done1, cout1, ovf1;  logic [W-1:0] s1;
    logic busy16, done16, cout16, ovf16; logic [W-1:0] s16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    digit_serial_addsub #(.WIDTH(W), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4));
    digit_serial_addsub #(.WIDTH(W), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));
    digit_serial_addsub #(.WIDTH(W), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16));

    typedef struct {
        logic         mode;
        logic [W-1:0] a, b;
        logic [W-1:0] s;
        logic         cout, ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: sign-agreement overflow rule on a 17-bit sum.
    function automatic logic [W+1:0] ref_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] yy;
        logic [W:0]   sum;
        logic         v;
        yy  = m ? ~y : y;
        sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, m};
        v   = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
        return {v, sum};
    endfunction

    // Launch on dut4 and wait for its done; lat counts edges after the start edge.
    task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic busy_ok);
        mode = m; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~x; b = ~y; mode = ~m;
        busy_ok = busy4;
        lat = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (done4) begin
                lat = t;
                break;
            end
            if (!busy4) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int lat, l1, l4, l16;
        logic bok, done_at_start;
        logic [W+1:0] r;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FF0, 16'h2224, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 16'hABCD, 16'h1234, 16'hBE01, 1'b0, 1'b0};

        #12;
        check("reset busy", busy4, 0);
        check("reset done", done4, 0);
        check("reset s", s4, 0);
        check("reset cout", cout4, 0);
        check("reset ovf", ovf4, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, lat, bok);
            check($sformatf("vec%0d latency", i), lat, 4);
            check($sformatf("vec%0d busy", i), bok, 1);
            check($sformatf("vec%0d s", i), s4, vecs[i].s);
            check($sformatf("vec%0d cout", i), cout4, vecs[i].cout);
            check($sformatf("vec%0d ovf", i), ovf4, vecs[i].ovf);
            tick();
            check($sformatf("vec%0d done width", i), done4, 0);
        end

        // start re-pulsed two cycles into an operation is ignored
        mode = 1'b0; a = 16'h1234; b = 16'h0FF0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        mode = 1'b1; a = 16'h0100; b = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore not done early", done4, 0);
        tick();
        check("ignore done", done4, 1);
        check("ignore s", s4, 16'h2224);
        tick();
        check("ignore no second op", busy4, 0);
        tick();

        // back-to-back: start in the done cycle
        run_op(1'b0, 16'h0101, 16'h0202, lat, bok);
        done_at_start = done4;
        check("b2b first s", s4, 16'h0303);
        run_op(1'b1, 16'h1000, 16'h0001, lat, bok);
        check("b2b start in done cycle", done_at_start, 1);
        check("b2b latency", lat, 4);
        check("b2b second s", s4, 16'h0FFF);
        check("b2b second cout", cout4, 1);

        // asynchronous reset mid-operation
        mode = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        check("async rst busy", busy4, 0);
        check("async rst done", done4, 0);
        check("async rst s", s4, 0);
        check("async rst cout", cout4, 0);
        check("async rst ovf", ovf4, 0);
        #12 rst_n = 1'b1;
        bok = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (done4 || busy4) bok = 1'b0;
        end
        check("no done after reset", bok, 1);
        run_op(1'b0, 16'h7FFF, 16'h7FFF, lat, bok);
        check("post reset latency", lat, 4);
        check("post reset s", s4, 16'hFFFE);
        check("post reset ovf", ovf4, 1);
        for (int t = 0; t < 20; t++) tick();

        // random sweep on all three configurations at once
        for (int n = 0; n < 1000; n++) begin
            mode = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            r = ref_op(mode, a, b);
            start = 1'b1;
            tick();
            start = 1'b0;
            l1 = 0; l4 = 0; l16 = 0;
            for (int t = 1; t <= 17; t++) begin
                tick();
                if (done1 && l1 == 0) begin
                    l1 = t;
                    check("rand d1 result", {ovf1, cout1, s1}, r);
                end
                if (done4 && l4 == 0) begin
                    l4 = t;
                    check("rand d4 result", {ovf4, cout4, s4}, r);
                end
                if (done16 && l16 == 0) begin
                    l16 = t;
                    check("rand d16 result", {ovf16, cout16, s16}, r);
                end
            end
            check("rand d1 latency", l1, 16);
            check("rand d4 latency", l4, 4);
            check("rand d16 latency", l16, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/digit_serial_addsub.md
Name: digit_serial_addsub

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor. It processes operands DIGIT bits per clock, least-significant digit first, through a DIGIT-wide ripple adder slice. Operands and the result are handled as WIDTH-bit words. Intended for datapaths where a wide single-cycle ripple chain is too slow or too large, and where area is traded for latency. Provides a start/busy/done handshake plus carry and signed-overflow flags.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock cycle; 1 <= DIGIT <= WIDTH.
(derived) NDIG = WIDTH/DIGIT, number of digit cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only when busy=0
mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when s/cout/ovf update
s  output  WIDTH  result; holds its value between completions
cout  output  1  carry out of the MSB (for subtract, 1 = no borrow)
ovf  output  1  signed overflow of the completed operation

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, s=0, cout=0, ovf=0. All internal operand registers, the carry register and the digit counter are cleared.
- Reset mid-operation aborts it. No done pulse is produced, s is 0 after reset, and the aborted operation never completes.
- States: IDLE and RUN.
- IDLE:
  - start=1 at rising edge k: capture A=a, B'=b XOR {WIDTH{mode}}, carry=mode, digit counter=0; go to RUN.
  - busy=1 from edge k onward.
- RUN, edge k+i (i = 1..NDIG):
  - Add digit i-1 of A, digit i-1 of B' and carry, then register the DIGIT-bit sum and the carry.
  - Keep the carry into the MSB stage for the overflow computation.
- Edge k+NDIG, in the same edge as the last digit:
  - s <= assembled sum; cout <= final carry; ovf <= carry_into_MSB XOR carry_out_of_MSB.
  - done <= 1, busy <= 0; go to IDLE.
- Latency: start to done is exactly NDIG cycles. done is high for exactly one cycle.
- s, cout and ovf change only on a done edge or on reset; they are stable while busy=1.
- start while busy=1 is ignored, and a, b and mode changes during RUN have no effect.
- start=1 in the cycle done=1 (busy=0) is accepted. This gives back-to-back operations with a throughput of one result per NDIG cycles and no idle gap.
- Arithmetic is modulo 2^WIDTH.
  - Add: cout = unsigned carry out.
  - Subtract: computes a + ~b + 1; cout=1 iff a >= b (unsigned).
  - ovf follows the signed two's-complement rule for both modes.
- DIGIT=WIDTH gives NDIG=1: done follows start by one cycle. DIGIT=1 gives a bit-serial operation.
- The digit counter is ceil(log2(NDIG+1)) bits wide and never wraps past NDIG within an operation.

Test Plan:
WIDTH=16, DIGIT=4 unless stated otherwise.
1. Add: start with a=0x1234, b=0x0FF0, mode=0 -> done exactly 4 cycles later; s=0x2224, cout=0, ovf=0; busy high for those 4 cycles.
2. Subtract with borrow: a=0x0005, b=0x0007, mode=1 -> s=0xFFFE, cout=0, ovf=0. Then a=0x0007, b=0x0005 -> s=0x0002, cout=1, ovf=0.
3. Overflow corners:
   - 0x7FFF+0x0001 -> s=0x8000, ovf=1, cout=0.
   - 0x8000-0x0001 -> s=0x7FFF, ovf=1, cout=1.
   - 0xFFFF+0x0001 -> s=0x0000, cout=1, ovf=0.
4. Handshake:
   - start pulsed again, with different operands, 2 cycles into an operation -> ignored; the result equals the first operation's result.
   - start asserted in the done cycle -> second done exactly 4 cycles after the first done.
5. Reset: deassert rst_n asynchronously (between clock edges) during cycle 2 of an operation -> busy, done, s, cout and ovf go to 0 immediately; no done pulse after rst_n is released. A new operation then completes correctly.
6. Parameter sweep: DIGIT=1 (16-cycle latency) and DIGIT=16 (1-cycle latency); 1000 random a, b, mode per configuration -> s, cout and ovf match a reference model, and the latency matches NDIG.
